// File: rtl/hack_mem_pkg.sv
// Shared widths, Hack memory map constants and the access legality rule
// used by the data-memory arbiter.
package hack_mem_pkg;

    localparam int HACK_ADDR_W = 15;
    localparam int HACK_DATA_W = 16;

    localparam logic [HACK_ADDR_W-1:0] SCREEN_BASE = 15'h4000;
    localparam logic [HACK_ADDR_W-1:0] KBD_ADDR    = 15'h6000;

    // Anything above the keyboard register is unmapped; the keyboard itself
    // is read-only unless the instance explicitly allows writes to it.
    function automatic logic access_legal(
        input logic [HACK_ADDR_W-1:0] addr,
        input logic                   we,
        input logic [HACK_ADDR_W-1:0] kbd_addr,
        input logic                   kbd_writable
    );
        return (addr <= kbd_addr) && !(we && (addr == kbd_addr) && !kbd_writable);
    endfunction

endpackage

// File: rtl/hack_mem_arbiter_rport.sv
// Per-port read-return stage: captures memory data on a granted read and
// presents it with a one-cycle valid pulse; illegal reads return zero.
module hack_mem_arbiter_rport
    import hack_mem_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic                   legal,
    input  logic [HACK_DATA_W-1:0] mem_out,
    output logic                   rvalid,
    output logic [HACK_DATA_W-1:0] rdata
);

    logic                   rvalid_reg;
    logic [HACK_DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= rd_en;
            // rdata is sticky between reads so a slow consumer can still see it
            if (rd_en) begin
                rdata_reg <= legal ? mem_out : '0;
            end
        end
    end

    assign rvalid = rvalid_reg;
    assign rdata  = rdata_reg;

endmodule

// File: rtl/hack_mem_arbiter.sv
// Two-port arbiter for the single-port Hack data memory: CPU port A has
// fixed priority, display port B is force-granted after MAX_WAIT denials.
module hack_mem_arbiter
    import hack_mem_pkg::*;
#(
    parameter int                   MAX_WAIT     = 4,
    parameter logic [14:0]          KBD_ADDR     = hack_mem_pkg::KBD_ADDR,
    parameter logic                 KBD_WRITABLE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [14:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [14:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [15:0] b_rdata,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_in,
    output logic        mem_ld,
    input  logic [15:0] mem_out
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]  wait_cnt_reg;
    logic        err_reg;
    logic        force_b;
    logic        a_sel;
    logic        b_sel;

    // Index 0 is port A, index 1 is port B.
    logic [1:0]                   sel;
    logic [1:0]                   we;
    logic [1:0]                   legal;
    logic [1:0]                   rvalid;
    logic [1:0][HACK_DATA_W-1:0]  rdata;

    assign force_b = b_req && (wait_cnt_reg == MAX_WAIT_C);
    // Nothing is granted while reset is high so no write can slip through.
    assign a_sel   = !reset && a_req && !force_b;
    assign b_sel   = !reset && b_req && (force_b || !a_req);

    assign sel      = {b_sel, a_sel};
    assign we       = {b_we, a_we};
    assign legal[0] = access_legal(a_addr, a_we, KBD_ADDR, KBD_WRITABLE);
    assign legal[1] = access_legal(b_addr, b_we, KBD_ADDR, KBD_WRITABLE);

    assign a_gnt = a_sel;
    assign b_gnt = b_sel;

    // Idle cycles park the bus on port A's values with the load disabled.
    assign mem_addr = {1'b0, (b_sel ? b_addr : a_addr)};
    assign mem_in   = b_sel ? b_wdata : a_wdata;
    assign mem_ld   = |(sel & we & legal);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= |(sel & ~legal);
            if (b_req && !b_sel) begin
                wait_cnt_reg <= (wait_cnt_reg == MAX_WAIT_C) ? wait_cnt_reg
                                                             : wait_cnt_reg + 4'd1;
            end else begin
                wait_cnt_reg <= '0;
            end
        end
    end

    assign err = err_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
        hack_mem_arbiter_rport u_rport (
            .clk     (clk),
            .reset   (reset),
            .rd_en   (sel[gi] && !we[gi]),
            .legal   (legal[gi]),
            .mem_out (mem_out),
            .rvalid  (rvalid[gi]),
            .rdata   (rdata[gi])
        );
    end

    assign a_rvalid = rvalid[0];
    assign a_rdata  = rdata[0];
    assign b_rvalid = rvalid[1];
    assign b_rdata  = rdata[1];

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Bench for hack_mem_arbiter: a stand-in memory, a transaction-level model
// compared every cycle, and directed scenarios with literal expectations.
module tb_hack_mem_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [14:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, err, mem_ld;
    logic [15:0] a_rdata, b_rdata, mem_addr, mem_in, mem_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hack_mem_arbiter #(.MAX_WAIT(MAXW), .KBD_ADDR(15'h6000), .KBD_WRITABLE(1'b0)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .err(err), .mem_addr(mem_addr), .mem_in(mem_in), .mem_ld(mem_ld),
        .mem_out(mem_out)
    );

    // Stand-in for the Hack memory top: combinational read, write on the edge.
    logic [15:0] ram [0:32767];
    assign mem_out = ram[mem_addr[14:0]];
    always @(posedge clk) if (mem_ld) ram[mem_addr[14:0]] <= mem_in;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] shadow [0:32767];
    int          denied_run = 0;
    bit          live = 0;
    logic        m_a_rvalid, m_b_rvalid, m_err;
    logic [15:0] m_a_rdata, m_b_rdata;

    function automatic bit ok(input bit w, input logic [14:0] ad);
        return (ad < 15'h6000) || (ad == 15'h6000 && !w);
    endfunction

    // Who wins this cycle: 0 none, 1 A, 2 B.
    function automatic int winner();
        if (reset) return 0;
        if (b_req && denied_run >= MAXW) return 2;
        if (a_req) return 1;
        if (b_req) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        int w;
        w = winner();
        live = 1;
        if (reset) begin
            denied_run = 0;
            m_a_rvalid = 0; m_b_rvalid = 0; m_err = 0;
            m_a_rdata = 0;  m_b_rdata = 0;
        end else begin
            m_a_rvalid = (w == 1) && !a_we;
            m_b_rvalid = (w == 2) && !b_we;
            m_err = (w == 1 && !ok(a_we, a_addr)) || (w == 2 && !ok(b_we, b_addr));
            if (m_a_rvalid) m_a_rdata = ok(0, a_addr) ? shadow[a_addr] : 16'h0;
            if (m_b_rvalid) m_b_rdata = ok(0, b_addr) ? shadow[b_addr] : 16'h0;
            if (w == 1 && a_we && ok(1, a_addr)) shadow[a_addr] = a_wdata;
            if (w == 2 && b_we && ok(1, b_addr)) shadow[b_addr] = b_wdata;
            denied_run = (b_req && w != 2) ? ((denied_run < MAXW) ? denied_run + 1 : MAXW) : 0;
        end
    end

    always @(negedge clk) begin
        int w;
        if (live) begin
            w = winner();
            check("a_gnt", 16'(a_gnt), 16'(w == 1));
            check("b_gnt", 16'(b_gnt), 16'(w == 2));
            check("mem_addr", mem_addr, {1'b0, (w == 2) ? b_addr : a_addr});
            check("mem_in", mem_in, (w == 2) ? b_wdata : a_wdata);
            check("mem_ld", 16'(mem_ld),
                  16'((w == 1 && a_we && ok(1, a_addr)) || (w == 2 && b_we && ok(1, b_addr))));
            check("a_rvalid", 16'(a_rvalid), 16'(m_a_rvalid));
            check("b_rvalid", 16'(b_rvalid), 16'(m_b_rvalid));
            check("a_rdata", a_rdata, m_a_rdata);
            check("b_rdata", b_rdata, m_b_rdata);
            check("err", 16'(err), 16'(m_err));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic rst,
                         input logic ar, input logic aw, input logic [14:0] aa, input logic [15:0] ad,
                         input logic br, input logic bw, input logic [14:0] ba, input logic [15:0] bd);
        @(posedge clk);
        #1;
        reset = rst;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        $display("txn t=%0t rst=%0b A(req=%0b we=%0b addr=%h d=%h) B(req=%0b we=%0b addr=%h d=%h)",
                 $time, rst, ar, aw, aa, ad, br, bw, ba, bd);
    endtask

    task automatic idle(input logic rst);
        drive(rst, 0, 0, 15'h0, 16'h0, 0, 0, 15'h0, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] bpat;
        for (int i = 0; i < 32768; i++) begin
            ram[i] = 16'h0;
            shadow[i] = 16'h0;
        end
        for (int i = 0; i < 4; i++) begin
            ram[i] = 16'(i + 1);
            shadow[i] = 16'(i + 1);
        end
        ram[15'h6000] = 16'hAAAA; shadow[15'h6000] = 16'hAAAA;
        ram[15'h7000] = 16'h5555; shadow[15'h7000] = 16'h5555;

        reset = 1; a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        idle(1); idle(1);
        @(negedge clk);
        check("rst_a_rvalid", 16'(a_rvalid), 16'h0);
        check("rst_err", 16'(err), 16'h0);
        check("rst_a_rdata", a_rdata, 16'h0);
        check("rst_mem_ld", 16'(mem_ld), 16'h0);
        idle(0);

        // Single A write then read back
        drive(0, 1, 1, 15'h0010, 16'hBEEF, 0, 0, 15'h0, 16'h0);
        @(negedge clk);
        check("wr_mem_ld", 16'(mem_ld), 16'h1);
        drive(0, 1, 0, 15'h0010, 16'h0, 0, 0, 15'h0, 16'h0);
        @(negedge clk);
        check("wr_no_rvalid", 16'(a_rvalid), 16'h0);
        idle(0);
        @(negedge clk);
        check("rd_a_rvalid", 16'(a_rvalid), 16'h1);
        check("rd_a_rdata", a_rdata, 16'hBEEF);

        // Contention: both held for 10 cycles
        bpat = '0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 15'h0001, 16'h0, 1, 0, 15'h0100, 16'h0);
            @(negedge clk);
            bpat[i] = b_gnt;
            check("one_gnt", 16'(a_gnt ^ b_gnt), 16'h1);
        end
        check("contention_pattern", 16'(bpat), 16'(10'b10_0001_0000));
        idle(0);

        // Screen and keyboard decode through port B, then rejected KBD write
        drive(0, 0, 0, 15'h0, 16'h0, 1, 1, 15'h4000, 16'h1234);
        drive(0, 0, 0, 15'h0, 16'h0, 1, 1, 15'h5FFF, 16'h1234);
        drive(0, 0, 0, 15'h0, 16'h0, 1, 0, 15'h4000, 16'h0);
        drive(0, 0, 0, 15'h0, 16'h0, 1, 0, 15'h5FFF, 16'h0);
        @(negedge clk);
        check("scr_rdata0", b_rdata, 16'h1234);
        check("scr_err0", 16'(err), 16'h0);
        drive(0, 1, 1, 15'h6000, 16'h00FF, 0, 0, 15'h0, 16'h0);
        @(negedge clk);
        check("scr_rdata1", b_rdata, 16'h1234);
        check("kbd_mem_ld", 16'(mem_ld), 16'h0);
        check("kbd_gnt", 16'(a_gnt), 16'h1);
        idle(0);
        @(negedge clk);
        check("kbd_err", 16'(err), 16'h1);
        check("kbd_unchanged", ram[15'h6000], 16'hAAAA);
        idle(0);
        @(negedge clk);
        check("kbd_err_pulse", 16'(err), 16'h0);

        // Out-of-range read
        drive(0, 1, 0, 15'h7000, 16'h0, 0, 0, 15'h0, 16'h0);
        @(negedge clk);
        check("oor_gnt", 16'(a_gnt), 16'h1);
        idle(0);
        @(negedge clk);
        check("oor_rvalid", 16'(a_rvalid), 16'h1);
        check("oor_rdata", a_rdata, 16'h0);
        check("oor_err", 16'(err), 16'h1);

        // Back-to-back reads of preloaded words
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(0, 1, 0, 15'(i), 16'h0, 0, 0, 15'h0, 16'h0);
            else idle(0);
            @(negedge clk);
            if (i > 0) begin
                check("b2b_rvalid", 16'(a_rvalid), 16'h1);
                check("b2b_rdata", a_rdata, 16'(i));
            end
        end
        idle(0);

        // Reset in the cycle after a granted read, with B already waiting
        drive(0, 1, 0, 15'h0010, 16'h0, 1, 0, 15'h0100, 16'h0);
        drive(1, 1, 1, 15'h0010, 16'h0BAD, 1, 0, 15'h0100, 16'h0);
        @(negedge clk);
        check("rst_gnt", 16'(a_gnt | b_gnt), 16'h0);
        check("rst_ld", 16'(mem_ld), 16'h0);
        bpat = '0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 15'h0001, 16'h0, 1, 0, 15'h0100, 16'h0);
            @(negedge clk);
            if (i == 0) begin
                check("post_rst_rvalid", 16'(a_rvalid), 16'h0);
                check("post_rst_err", 16'(err), 16'h0);
            end
            bpat[i] = b_gnt;
        end
        check("post_rst_pattern", 16'(bpat), 16'(10'b00_0001_0000));
        check("rst_write_blocked", ram[15'h0010], 16'hBEEF);
        idle(0);
        idle(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
